// File: rtl/mux2_arbiter_if.sv
// Handshake bundle for the two-source packet arbiter:
// two valid/ready/last sources and one registered sink.
interface mux2_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-source packet arbiter: round-robin on ties, grant locked
// for a whole packet, single registered output stage.
module mux2_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_arbiter_if.slave  bus,
  output logic           sel,
  output logic           busy
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_out_valid;
  logic             r_out_last;
  logic [WIDTH-1:0] r_out_data;
  logic             w_room;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_done;

  assign w_room = !r_out_valid || bus.out_ready;

  // Gated by rst_n so no source sees a handshake while in reset.
  assign bus.in0_ready = rst_n && (r_state == GRANT0) && w_room;
  assign bus.in1_ready = rst_n && (r_state == GRANT1) && w_room;

  assign w_xfer0 = bus.in0_valid && bus.in0_ready;
  assign w_xfer1 = bus.in1_valid && bus.in1_ready;
  assign w_done  = (w_xfer0 && bus.in0_last)
                || (w_xfer1 && bus.in1_last);

  assign busy = rst_n && (r_state != IDLE);
  assign sel  = rst_n && (r_state == GRANT1);

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.in0_valid && bus.in1_valid)
          w_next = r_ptr ? GRANT1 : GRANT0;
        else if (bus.in0_valid)
          w_next = GRANT0;
        else if (bus.in1_valid)
          w_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (w_done)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer0 && bus.in0_last)
        r_ptr <= 1'b1;
      else if (w_xfer1 && bus.in1_last)
        r_ptr <= 1'b0;
      if (w_xfer0) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in0_data;
        r_out_last  <= bus.in0_last;
      end else if (w_xfer1) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in1_data;
        r_out_last  <= bus.in1_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed scenarios plus random traffic,
// checked each cycle against a packet-level reference model.
module tb_mux2_arbiter;
  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel;
  logic busy;

  mux2_arbiter_if #(.WIDTH(8)) bus();

  mux2_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sel   (sel),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gap = 0;
  int ordy_pct = 100;

  beat_t      q0[$];
  beat_t      q1[$];
  logic [7:0] outlog[$];
  logic [7:0] expq[$];
  int         acc0[$];

  // reference model state
  int         owner = -1;
  int         fav = 0;
  bit         model_ok = 0;
  bit         m_ov = 0;
  logic [7:0] m_od = '0;
  logic       m_ol = 1'b0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_seq(string tag);
    chk({tag, "_len"}, outlog.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < outlog.size())
        chk(tag, outlog[i], expq[i]);
    end
  endtask

  task automatic add_beat(int s, logic [7:0] d, logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (s == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic add_pkt(int s);
    int n;
    n = $urandom_range(4, 1);
    for (int i = 0; i < n; i++)
      add_beat(s, 8'($urandom), (i == n - 1));
  endtask

  // One clock cycle: drive, check vs model, advance model.
  task automatic tick();
    bit v0, v1, ordy, e0, e1, a0, a1;
    logic [7:0] d0, d1;
    logic l0, l1;
    v0 = (q0.size() > 0) && ($urandom_range(99) >= gap);
    v1 = (q1.size() > 0) && ($urandom_range(99) >= gap);
    d0 = v0 ? q0[0].d : 8'($urandom);
    l0 = v0 ? q0[0].l : 1'($urandom);
    d1 = v1 ? q1[0].d : 8'($urandom);
    l1 = v1 ? q1[0].l : 1'($urandom);
    ordy = ($urandom_range(99) < ordy_pct);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in0_last  = l0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.in1_last  = l1;
    bus.out_ready = ordy;
    #1;
    e0 = rst_n && (owner == 0) && (!m_ov || ordy);
    e1 = rst_n && (owner == 1) && (!m_ov || ordy);
    if (model_ok) begin
      chk("in0_ready", bus.in0_ready, e0);
      chk("in1_ready", bus.in1_ready, e1);
      chk("busy", busy, rst_n && (owner != -1));
      chk("sel", sel, rst_n && (owner == 1));
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_od);
      chk("out_last", bus.out_last, m_ol);
    end
    if (rst_n && bus.out_valid && bus.out_ready)
      outlog.push_back(bus.out_data);
    a0 = v0 && bus.in0_ready;
    a1 = v1 && bus.in1_ready;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      owner = -1;
      fav = 0;
      m_ov = 0;
      m_od = '0;
      m_ol = 1'b0;
      model_ok = 1;
      q0.delete();
      q1.delete();
    end else begin
      if (v0 && e0) begin
        m_ov = 1; m_od = d0; m_ol = l0;
      end else if (v1 && e1) begin
        m_ov = 1; m_od = d1; m_ol = l1;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (owner == -1) begin
        if (v0 && v1) owner = fav;
        else if (v0)  owner = 0;
        else if (v1)  owner = 1;
      end else if ((owner == 0 && v0 && e0 && l0) ||
                   (owner == 1 && v1 && e1 && l1)) begin
        fav = 1 - owner;
        owner = -1;
      end
      if (a0) begin
        acc0.push_back(cyc);
        void'(q0.pop_front());
      end
      if (a1) void'(q1.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t0;
    bus.in0_valid = 0; bus.in0_data = '0; bus.in0_last = 0;
    bus.in1_valid = 0; bus.in1_data = '0; bus.in1_last = 0;
    bus.out_ready = 1;
    do_reset();
    do_reset();
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_od", bus.out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 1'b0);

    // single beat from source 0
    outlog.delete(); acc0.delete();
    t0 = cyc;
    add_beat(0, 8'h11, 1'b1);
    run(2);
    chk("r32_acc", acc0.size() > 0 ? acc0[0] : -1, t0 + 2);
    chk("r32_ov", bus.out_valid, 1'b1);
    chk("r32_od", bus.out_data, 8'h11);
    chk("r32_ol", bus.out_last, 1'b1);
    run(2);
    chk("r32_idle", busy, 1'b0);

    // repeated ties alternate
    do_reset();
    outlog.delete();
    add_beat(0, 8'hA0, 1); add_beat(0, 8'hA0, 1);
    add_beat(1, 8'hB0, 1); add_beat(1, 8'hB0, 1);
    run(10);
    expq = {8'hA0, 8'hB0, 8'hA0, 8'hB0};
    chk_seq("r33");

    // packet lock against a waiting source 1
    outlog.delete();
    add_beat(0, 8'h01, 0); add_beat(0, 8'h02, 0);
    add_beat(0, 8'h03, 1); add_beat(1, 8'hB1, 1);
    run(10);
    expq = {8'h01, 8'h02, 8'h03, 8'hB1};
    chk_seq("r34");

    // sink stall for four cycles
    outlog.delete();
    ordy_pct = 0;
    add_beat(0, 8'h55, 1); add_beat(0, 8'h56, 1);
    run(6);
    chk("r35_hold", bus.out_data, 8'h55);
    chk("r35_ov", bus.out_valid, 1'b1);
    chk("r35_rdy0", bus.in0_ready, 1'b0);
    chk("r35_rdy1", bus.in1_ready, 1'b0);
    ordy_pct = 100;
    tick();
    chk("r35_next", bus.out_data, 8'h56);
    run(3);
    expq = {8'h55, 8'h56};
    chk_seq("r35");

    // back-to-back packets: one arbitration cycle between
    acc0.delete();
    add_beat(0, 8'h01, 0); add_beat(0, 8'h02, 1);
    add_beat(0, 8'h03, 0); add_beat(0, 8'h04, 1);
    run(10);
    chk("r37_n", acc0.size(), 4);
    if (acc0.size() == 4) begin
      chk("r37_in", acc0[1] - acc0[0], 1);
      chk("r37_gap", acc0[2] - acc0[1], 2);
    end

    // reset in the middle of a source 1 packet
    add_beat(1, 8'hC1, 0); add_beat(1, 8'hC2, 0);
    add_beat(1, 8'hC3, 1);
    run(3);
    do_reset();
    chk("r36_ov", bus.out_valid, 1'b0);
    chk("r36_busy", busy, 1'b0);
    outlog.delete();
    add_beat(0, 8'hD0, 1); add_beat(1, 8'hE0, 1);
    run(6);
    expq = {8'hD0, 8'hE0};
    chk_seq("r36");

    // random traffic
    gap = 25;
    ordy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2 && $urandom_range(3) == 0) add_pkt(0);
      if (q1.size() < 2 && $urandom_range(3) == 0) add_pkt(1);
      if ($urandom_range(299) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits of each source and of the sink.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 in0_valid  input  1  source 0 beat valid.
REQ-005 in0_data  input  WIDTH  source 0 payload.
REQ-006 in0_last  input  1  source 0 final beat of packet.
REQ-007 in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid.
REQ-008 in1_valid, in1_data, in1_last, in1_ready  same directions/widths/meanings as source 0, for source 1.
REQ-009 out_valid  output  1  registered sink beat valid.
REQ-010 out_data  output  WIDTH  registered sink payload.
REQ-011 out_last  output  1  registered sink last-beat flag.
REQ-012 out_ready  input  1  sink accepts beat when high with out_valid.
REQ-013 sel  output  1  index of currently granted source (0 or 1); meaningful only when busy is high.
REQ-014 busy  output  1  high while a source holds the grant.

Function
REQ-015 FSM states IDLE, GRANT0, GRANT1; sel = 1 in GRANT1, else 0; busy = 1 in GRANT0/GRANT1.
REQ-016 IDLE: only in0_valid -> GRANT0; only in1_valid -> GRANT1; both -> source selected by priority pointer; neither -> stay IDLE.
REQ-017 Priority pointer: 1 bit, holds index of favoured source; after any last beat of source x is transferred, pointer becomes the other source.
REQ-018 No input is ready in IDLE; grant takes effect the cycle after arbitration, so first beat transfers no earlier than one cycle after valid is first seen.
REQ-019 inX_ready = (state == GRANTX) and (out_valid == 0 or out_ready == 1); the non-granted source's ready is always 0.
REQ-020 Transfer from source X occurs when inX_valid and inX_ready; output register then loads inX_data, inX_last and sets out_valid = 1 on the next edge.
REQ-021 When out_valid and out_ready and no transfer occurs, out_valid clears to 0 next edge; out_data/out_last hold their last value.
REQ-022 Simultaneous sink pop and source transfer: out register reloads, out_valid stays 1; sustained throughput one beat per cycle.
REQ-023 out_valid high and out_ready low: out_valid, out_data, out_last held stable; no input ready.
REQ-024 Grant is locked for a whole packet: GRANTX persists, regardless of the other source, until a transfer with inX_last = 1.
REQ-025 Transfer with last = 1: next state IDLE and pointer updated in the same edge; the final beat still drains through the output register normally.
REQ-026 inX_valid deasserting mid-packet while granted: grant held, no transfer, no state change.
REQ-027 A single-beat packet (last = 1 on first beat) is legal and follows REQ-025.
REQ-028 Data path is a pure selection; no payload bit is modified, widened or truncated.

Reset
REQ-029 When rst_n is low at a rising edge: state = IDLE, pointer = 0 (source 0 favoured), out_valid = 0, out_data = 0, out_last = 0.
REQ-030 During and immediately after reset, in0_ready = in1_ready = 0, sel = 0, busy = 0.
REQ-031 Reset mid-packet or with out_valid high discards the in-flight beat and grant without producing any further output beat.

Verification
REQ-032 Reset, then in0_valid = 1 alone with data 0x11, last = 1, out_ready = 1 -> in0_ready high in cycle 1, out_valid = 1 with out_data = 0x11, out_last = 1 in cycle 2, then IDLE.
REQ-033 Both valid after reset, each a 1-beat packet (0xA0, 0xB0) -> out sequence 0xA0 then 0xB0; a repeated tie gives 0xA0 then 0xB0 again (pointer alternation).
REQ-034 Source 0 sends a 3-beat packet 0x01,0x02,0x03 while in1_valid is held high -> all three beats output before any source 1 beat; sel = 0 throughout.
REQ-035 out_ready low for 4 cycles with out_valid high carrying 0x55 -> out_data stable at 0x55, both readys 0; on out_ready high the next beat follows with no gap or loss.
REQ-036 rst_n low for one cycle in the middle of a source 1 packet -> out_valid = 0, busy = 0 the following cycle; next tie grants source 0.
REQ-037 Back-to-back packets with out_ready always high -> exactly one idle (arbitration) cycle between the last beat of one packet and the first beat of the next at the input side.
